// File: rtl/test_counter_pkg.sv
// Shared defaults and count type for the test_counter terminal-count event counter.
package test_counter_pkg;
  localparam int unsigned WIDTH_DEF    = 4;
  localparam int unsigned TERMINAL_DEF = 9;

  typedef logic [WIDTH_DEF-1:0] count_t;
endpackage

// File: rtl/test_counter_edge_detect.sv
// Samples the event input and flags each low-to-high transition for one cycle.
// Optional input synchroniser selected by macro TEST_COUNTER_SYNC_EN.
module edge_detect
  import test_counter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic rise
);
  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic smp;

`ifdef TEST_COUNTER_SYNC_EN
  // meta_q and s1_q together form the two-flop synchroniser
  logic meta_q, meta_d;

  always_comb begin
    meta_d = in;
    smp    = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) meta_q <= 1'b0;
    else        meta_q <= meta_d;
  end
`else
  always_comb smp = in;
`endif

  always_comb begin
    s1_d = smp;
    s2_d = s1_q;
    rise = s1_q & ~s2_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end
endmodule

// File: rtl/test_counter.sv
// Counts rising edges of in, wraps after TERMINAL and emits a one-cycle registered pulse.
// Build option TEST_COUNTER_SYNC_EN adds an input synchroniser (one extra cycle latency).
module test_counter
  import test_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned TERMINAL = TERMINAL_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic out
);
  logic             rise;
  logic [WIDTH-1:0] count_q, count_d;
  logic             out_q, out_d;

  edge_detect u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in),
    .rise  (rise)
  );

  always_comb begin
    count_d = count_q;
    out_d   = 1'b0;
    if (rise) begin
      if (count_q == WIDTH'(TERMINAL)) begin
        count_d = '0;
        out_d   = 1'b1;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  // reset wins over a coincident edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      out_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      out_q   <= out_d;
    end
  end

  assign out = out_q;
endmodule

// File: tb/tb_test_counter.sv
// Directed self-checking bench for test_counter (default parameters).
module tb_test_counter;
  import test_counter_pkg::*;

`ifdef TEST_COUNTER_SYNC_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk;
  logic rst_n;
  logic in_s;
  logic out;

  int n_tests = 0;
  int n_fail  = 0;
  count_t exp_cnt;

  test_counter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in_s),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One single-cycle high pulse followed by three low cycles; checks out and count.
  task automatic do_pulse(input string tag);
    count_t nxt;
    logic   wrap;
    wrap = (exp_cnt == count_t'(TERMINAL_DEF));
    nxt  = wrap ? count_t'(0) : exp_cnt + count_t'(1);
    in_s = 1'b1;
    cyc();
    check({tag, "_out_early"}, {31'd0, out}, 32'd0);
    in_s = 1'b0;
    for (int d = 1; d <= 3; d++) begin
      cyc();
      check({tag, "_out"}, {31'd0, out}, {31'd0, (wrap && d == 1 + LAT)});
      check({tag, "_cnt"}, {28'd0, dut.count_q}, {28'd0, (d >= 1 + LAT) ? nxt : exp_cnt});
    end
    exp_cnt = nxt;
  endtask

  initial begin
    rst_n   = 1'b0;
    in_s    = 1'b0;
    exp_cnt = '0;

    // Reset held with in toggling
    for (int i = 0; i < 3; i++) begin
      in_s = ~in_s;
      cyc();
      check("rst_out", {31'd0, out}, 32'd0);
      check("rst_cnt", {28'd0, dut.count_q}, 32'd0);
    end
    in_s = 1'b0;
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    check("post_rst_cnt", {28'd0, dut.count_q}, 32'd0);

    // Ten pulses: single wrap pulse after the tenth
    for (int i = 0; i < 10; i++) do_pulse("ten_pulses");
    check("ten_pulses_final_cnt", {28'd0, dut.count_q}, 32'd0);

    // Toggle every cycle: out every 20 cycles
    in_s = 1'b1;
    for (int j = 1; j <= 60 + LAT; j++) begin
      cyc();
      check("toggle_out", {31'd0, out}, {31'd0, (j > LAT && (j - LAT) % 20 == 0)});
      in_s = ~in_s;
    end
    in_s = 1'b0;
    repeat (3) cyc();
    check("toggle_end_cnt", {28'd0, dut.count_q}, 32'd0);
    check("toggle_end_out", {31'd0, out}, 32'd0);

    // Held high counts once, held low never counts
    in_s = 1'b1;
    for (int j = 0; j < 50; j++) begin
      cyc();
      check("hold_hi_out", {31'd0, out}, 32'd0);
    end
    check("hold_hi_cnt", {28'd0, dut.count_q}, 32'd1);
    in_s = 1'b0;
    repeat (20) cyc();
    check("hold_lo_cnt", {28'd0, dut.count_q}, 32'd1);
    exp_cnt = count_t'(1);

    // Reach count 7, then reset coincident with an edge
    for (int i = 0; i < 6; i++) do_pulse("to_seven");
    check("seven_cnt", {28'd0, dut.count_q}, 32'd7);
    in_s = 1'b1;
    repeat (1 + LAT) cyc();
    rst_n = 1'b0;
    cyc();
    check("rst_edge_cnt", {28'd0, dut.count_q}, 32'd0);
    check("rst_edge_out", {31'd0, out}, 32'd0);
    rst_n = 1'b1;
    in_s  = 1'b0;
    repeat (3) cyc();
    check("rst_edge_settle_cnt", {28'd0, dut.count_q}, 32'd0);
    exp_cnt = '0;
    for (int i = 0; i < 10; i++) do_pulse("after_rst");
    check("after_rst_final_cnt", {28'd0, dut.count_q}, 32'd0);

    // In already high at reset release counts as one edge
    rst_n = 1'b0;
    in_s  = 1'b1;
    cyc();
    check("rel_hi_in_rst_cnt", {28'd0, dut.count_q}, 32'd0);
    rst_n = 1'b1;
    repeat (5) cyc();
    check("rel_hi_cnt", {28'd0, dut.count_q}, 32'd1);
    check("rel_hi_out", {31'd0, out}, 32'd0);
    in_s = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
